// File: rtl/per2axi_master.sv
// -----------------------------------------------------------------------------
// per2axi_master
//   Bridges the cluster peripheral interconnect (req/gnt, r_valid) onto an AXI4
//   master port. Each granted 32-bit peripheral access becomes one single-beat
//   AXI read or write on the 64-bit bus; only one transaction is in flight.
//
// Ports
//   clk_i, rst_ni              clock, asynchronous active-low reset
//   per_slave_*                peripheral side: request/grant, registered
//                              one-cycle response with id, rdata and error flag
//   axi_aw_*, axi_w_*, axi_b_* AXI4 write address / data / response channels
//   axi_ar_*, axi_r_*          AXI4 read address / data channels
//   busy_o                     high while a transaction is in progress
//
// Configuration
//   PER2AXI_ERR_RESP_EN        when defined, resp[1] of the final B/R beat is
//                              reported on per_slave_r_opc_o; otherwise the
//                              response code is ignored and r_opc is always 0.
// -----------------------------------------------------------------------------
module per2axi_master #(
    parameter int unsigned PER_ADDR_WIDTH = 32,
    parameter int unsigned PER_ID_WIDTH   = 5,
    parameter int unsigned AXI_ADDR_WIDTH = 32,
    parameter int unsigned AXI_DATA_WIDTH = 64,
    parameter int unsigned AXI_ID_WIDTH   = 6
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,

    input  logic                        per_slave_req_i,
    input  logic [PER_ADDR_WIDTH-1:0]   per_slave_add_i,
    input  logic                        per_slave_we_ni,
    input  logic [31:0]                 per_slave_wdata_i,
    input  logic [3:0]                  per_slave_be_i,
    input  logic [PER_ID_WIDTH-1:0]     per_slave_id_i,
    output logic                        per_slave_gnt_o,
    output logic                        per_slave_r_valid_o,
    output logic                        per_slave_r_opc_o,
    output logic [PER_ID_WIDTH-1:0]     per_slave_r_id_o,
    output logic [31:0]                 per_slave_r_rdata_o,

    output logic                        axi_aw_valid_o,
    output logic [AXI_ADDR_WIDTH-1:0]   axi_aw_addr_o,
    output logic [2:0]                  axi_aw_prot_o,
    output logic [7:0]                  axi_aw_len_o,
    output logic [2:0]                  axi_aw_size_o,
    output logic [1:0]                  axi_aw_burst_o,
    output logic [AXI_ID_WIDTH-1:0]     axi_aw_id_o,
    input  logic                        axi_aw_ready_i,

    output logic                        axi_w_valid_o,
    output logic [AXI_DATA_WIDTH-1:0]   axi_w_data_o,
    output logic [AXI_DATA_WIDTH/8-1:0] axi_w_strb_o,
    output logic                        axi_w_last_o,
    input  logic                        axi_w_ready_i,

    input  logic                        axi_b_valid_i,
    input  logic [1:0]                  axi_b_resp_i,
    input  logic [AXI_ID_WIDTH-1:0]     axi_b_id_i,
    output logic                        axi_b_ready_o,

    output logic                        axi_ar_valid_o,
    output logic [AXI_ADDR_WIDTH-1:0]   axi_ar_addr_o,
    output logic [2:0]                  axi_ar_prot_o,
    output logic [7:0]                  axi_ar_len_o,
    output logic [2:0]                  axi_ar_size_o,
    output logic [1:0]                  axi_ar_burst_o,
    output logic [AXI_ID_WIDTH-1:0]     axi_ar_id_o,
    input  logic                        axi_ar_ready_i,

    input  logic                        axi_r_valid_i,
    input  logic [AXI_DATA_WIDTH-1:0]   axi_r_data_i,
    input  logic [1:0]                  axi_r_resp_i,
    input  logic                        axi_r_last_i,
    input  logic [AXI_ID_WIDTH-1:0]     axi_r_id_i,
    output logic                        axi_r_ready_o,

    output logic                        busy_o
);

    // Number of address bits carried across; the rest are zero-filled.
    localparam int unsigned ADDR_COPY =
        (PER_ADDR_WIDTH < AXI_ADDR_WIDTH) ? PER_ADDR_WIDTH : AXI_ADDR_WIDTH;

    typedef enum logic [2:0] {
        IDLE,
        WR_REQ,
        WR_RESP,
        RD_REQ,
        RD_RESP
    } state_e;

    state_e                    state_q,   state_d;
    logic [PER_ADDR_WIDTH-1:0] add_q,     add_d;
    logic                      we_n_q,    we_n_d;
    logic [31:0]               wdata_q,   wdata_d;
    logic [3:0]                be_q,      be_d;
    logic [PER_ID_WIDTH-1:0]   id_q,      id_d;
    logic                      aw_done_q, aw_done_d;
    logic                      w_done_q,  w_done_d;
    logic                      r_valid_q, r_valid_d;
    logic                      r_opc_q,   r_opc_d;
    logic [PER_ID_WIDTH-1:0]   r_id_q,    r_id_d;
    logic [31:0]               r_rdata_q, r_rdata_d;

    logic                      lane;
    logic                      b_err;
    logic                      r_err;
    logic [AXI_ADDR_WIDTH-1:0] axi_addr;
    logic                      unused_inputs;

    // Upper or lower 32-bit half of the 64-bit bus.
    assign lane = add_q[2];

`ifdef PER2AXI_ERR_RESP_EN
    // SLVERR and DECERR both have resp[1] set.
    assign b_err = axi_b_resp_i[1];
    assign r_err = axi_r_resp_i[1];
`else
    assign b_err = 1'b0;
    assign r_err = 1'b0;
`endif

    // IDs are never checked: only one transaction is ever outstanding.
    assign unused_inputs = ^{axi_b_id_i, axi_r_id_i, axi_b_resp_i, axi_r_resp_i, add_q};

    always_comb begin
        axi_addr              = '0;
        axi_addr[ADDR_COPY-1:0] = add_q[ADDR_COPY-1:0];
    end

    assign axi_aw_addr_o  = axi_addr;
    assign axi_aw_prot_o  = 3'b000;
    assign axi_aw_len_o   = 8'h00;
    assign axi_aw_size_o  = 3'b010;
    assign axi_aw_burst_o = 2'b01;
    assign axi_aw_id_o    = '0;

    assign axi_w_data_o   = {wdata_q, wdata_q};
    assign axi_w_strb_o   = lane ? {be_q, 4'h0} : {4'h0, be_q};
    assign axi_w_last_o   = 1'b1;

    assign axi_ar_addr_o  = axi_addr;
    assign axi_ar_prot_o  = 3'b000;
    assign axi_ar_len_o   = 8'h00;
    assign axi_ar_size_o  = 3'b010;
    assign axi_ar_burst_o = 2'b01;
    assign axi_ar_id_o    = '0;

    assign per_slave_r_valid_o = r_valid_q;
    assign per_slave_r_opc_o   = r_opc_q;
    assign per_slave_r_id_o    = r_id_q;
    assign per_slave_r_rdata_o = r_rdata_q;
    assign busy_o              = (state_q != IDLE);

    always_comb begin
        state_d   = state_q;
        add_d     = add_q;
        we_n_d    = we_n_q;
        wdata_d   = wdata_q;
        be_d      = be_q;
        id_d      = id_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        r_valid_d = 1'b0;
        r_opc_d   = r_opc_q;
        r_id_d    = r_id_q;
        r_rdata_d = r_rdata_q;

        per_slave_gnt_o = 1'b0;
        axi_aw_valid_o  = 1'b0;
        axi_w_valid_o   = 1'b0;
        axi_b_ready_o   = 1'b0;
        axi_ar_valid_o  = 1'b0;
        axi_r_ready_o   = 1'b0;

        case (state_q)
            IDLE: begin
                per_slave_gnt_o = per_slave_req_i;
                if (per_slave_req_i) begin
                    add_d     = per_slave_add_i;
                    we_n_d    = per_slave_we_ni;
                    wdata_d   = per_slave_wdata_i;
                    be_d      = per_slave_be_i;
                    id_d      = per_slave_id_i;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    state_d   = per_slave_we_ni ? RD_REQ : WR_REQ;
                end
            end

            // AW and W complete independently, in either order or together;
            // the done flags remember which one has already handshaked.
            WR_REQ: begin
                axi_aw_valid_o = ~aw_done_q;
                axi_w_valid_o  = ~w_done_q;
                if (axi_aw_valid_o && axi_aw_ready_i) aw_done_d = 1'b1;
                if (axi_w_valid_o  && axi_w_ready_i)  w_done_d  = 1'b1;
                if (aw_done_d && w_done_d) state_d = WR_RESP;
            end

            WR_RESP: begin
                axi_b_ready_o = 1'b1;
                if (axi_b_valid_i) begin
                    state_d   = IDLE;
                    r_valid_d = 1'b1;
                    r_opc_d   = b_err;
                    r_id_d    = id_q;
                    r_rdata_d = '0;
                end
            end

            RD_REQ: begin
                axi_ar_valid_o = 1'b1;
                if (axi_ar_ready_i) state_d = RD_RESP;
            end

            // Non-final beats are accepted and dropped.
            RD_RESP: begin
                axi_r_ready_o = 1'b1;
                if (axi_r_valid_i && axi_r_last_i) begin
                    state_d   = IDLE;
                    r_valid_d = 1'b1;
                    r_opc_d   = r_err;
                    r_id_d    = id_q;
                    r_rdata_d = lane ? axi_r_data_i[63:32] : axi_r_data_i[31:0];
                end
            end

            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            add_q     <= '0;
            we_n_q    <= 1'b0;
            wdata_q   <= '0;
            be_q      <= '0;
            id_q      <= '0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            r_valid_q <= 1'b0;
            r_opc_q   <= 1'b0;
            r_id_q    <= '0;
            r_rdata_q <= '0;
        end else begin
            state_q   <= state_d;
            add_q     <= add_d;
            we_n_q    <= we_n_d;
            wdata_q   <= wdata_d;
            be_q      <= be_d;
            id_q      <= id_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
            r_valid_q <= r_valid_d;
            r_opc_q   <= r_opc_d;
            r_id_q    <= r_id_d;
            r_rdata_q <= r_rdata_d;
        end
    end

endmodule

// File: tb/tb_per2axi_master.sv
// Testbench for per2axi_master: table of directed transactions, a hand-written
// asynchronous-reset sequence, then randomized transactions checked against a
// reference model. An AXI slave responder with per-transaction delays lives
// in run_txn.
module tb_per2axi_master;

`ifdef PER2AXI_ERR_RESP_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    localparam logic [21:0] FIX_EXP = {3'b000, 8'h00, 3'b010, 2'b01, 6'h00};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_ni;
    logic        per_req, per_we_n, gnt, r_valid_o, r_opc;
    logic [31:0] per_add, per_wdata, r_rdata;
    logic [3:0]  per_be;
    logic [4:0]  per_id, r_id;
    logic        aw_valid, aw_ready, w_valid, w_ready, w_last, b_valid, b_ready;
    logic        ar_valid, ar_ready, r_valid, r_last, r_ready, busy;
    logic [31:0] aw_addr, ar_addr;
    logic [2:0]  aw_prot, aw_size, ar_prot, ar_size;
    logic [7:0]  aw_len, ar_len, w_strb;
    logic [1:0]  aw_burst, ar_burst, b_resp, r_resp;
    logic [5:0]  aw_id, ar_id, b_id, r_id_in;
    logic [63:0] w_data, r_data;

    per2axi_master #(
        .PER_ADDR_WIDTH(32), .PER_ID_WIDTH(5), .AXI_ADDR_WIDTH(32),
        .AXI_DATA_WIDTH(64), .AXI_ID_WIDTH(6)
    ) dut (
        .clk_i(clk), .rst_ni(rst_ni),
        .per_slave_req_i(per_req), .per_slave_add_i(per_add), .per_slave_we_ni(per_we_n),
        .per_slave_wdata_i(per_wdata), .per_slave_be_i(per_be), .per_slave_id_i(per_id),
        .per_slave_gnt_o(gnt), .per_slave_r_valid_o(r_valid_o), .per_slave_r_opc_o(r_opc),
        .per_slave_r_id_o(r_id), .per_slave_r_rdata_o(r_rdata),
        .axi_aw_valid_o(aw_valid), .axi_aw_addr_o(aw_addr), .axi_aw_prot_o(aw_prot),
        .axi_aw_len_o(aw_len), .axi_aw_size_o(aw_size), .axi_aw_burst_o(aw_burst),
        .axi_aw_id_o(aw_id), .axi_aw_ready_i(aw_ready),
        .axi_w_valid_o(w_valid), .axi_w_data_o(w_data), .axi_w_strb_o(w_strb),
        .axi_w_last_o(w_last), .axi_w_ready_i(w_ready),
        .axi_b_valid_i(b_valid), .axi_b_resp_i(b_resp), .axi_b_id_i(b_id), .axi_b_ready_o(b_ready),
        .axi_ar_valid_o(ar_valid), .axi_ar_addr_o(ar_addr), .axi_ar_prot_o(ar_prot),
        .axi_ar_len_o(ar_len), .axi_ar_size_o(ar_size), .axi_ar_burst_o(ar_burst),
        .axi_ar_id_o(ar_id), .axi_ar_ready_i(ar_ready),
        .axi_r_valid_i(r_valid), .axi_r_data_i(r_data), .axi_r_resp_i(r_resp),
        .axi_r_last_i(r_last), .axi_r_id_i(r_id_in), .axi_r_ready_o(r_ready),
        .busy_o(busy)
    );

    typedef struct {
        logic        we_n;
        logic [31:0] add;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic [4:0]  id;
        int          aw_dly, w_dly, b_dly, ar_dly, r_dly, nbeats;
        logic [1:0]  b_resp, r_resp;
        logic [63:0] rdata;
        logic        hold;
        logic [31:0] exp_addr;
        logic [63:0] exp_wdata;
        logic [7:0]  exp_strb;
        logic [31:0] exp_rdata;
        logic        exp_opc;
        int          exp_lat;
    } txn_t;

    int total  = 0;
    int passed = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic idle_axi();
        aw_ready = 0; w_ready = 0; b_valid = 0; b_resp = 0; b_id = 0;
        ar_ready = 0; r_valid = 0; r_data = 0; r_resp = 0; r_last = 0; r_id_in = 0;
    endtask

    task automatic drive_req(input logic rq, input txn_t x);
        per_req = rq; per_add = x.add; per_we_n = x.we_n;
        per_wdata = x.wdata; per_be = x.be; per_id = x.id;
    endtask

    // Reference model: byte-lane arithmetic and handshake-timeline latency.
    function automatic txn_t expect_of(input txn_t t);
        txn_t        r;
        int unsigned half;
        int          kaw, kw, kb, kar, kr;
        r = t;
        half = (t.add / 4) % 2;
        r.exp_addr = t.add;
        r.exp_wdata = 64'(t.wdata) * 64'h0000_0001_0000_0001;
        r.exp_strb  = 8'(t.be) << (4 * half);
        if (!t.we_n) begin
            r.exp_rdata = 0;
            r.exp_opc   = ERR_EN && (t.b_resp >= 2);
            kaw = 1 + t.aw_dly;
            kw  = 1 + t.w_dly;
            kb  = ((kaw > kw) ? kaw : kw) + 1 + t.b_dly;
            r.exp_lat = kb + 1;
        end else begin
            r.exp_rdata = 32'(t.rdata >> (32 * half));
            r.exp_opc   = ERR_EN && (t.r_resp >= 2);
            kar = 1 + t.ar_dly;
            kr  = kar + 1 + t.r_dly + t.nbeats - 1;
            r.exp_lat = kr + 1;
        end
        return r;
    endfunction

    function automatic txn_t mk(input logic we_n, input logic [31:0] add, input logic [31:0] wdata,
                                input logic [3:0] be, input logic [4:0] id,
                                input int aw_dly, input int w_dly, input int b_dly,
                                input logic [1:0] bresp, input int ar_dly, input int r_dly,
                                input int nbeats, input logic [63:0] rdata,
                                input logic [1:0] rresp, input logic hold);
        txn_t t;
        t.we_n = we_n; t.add = add; t.wdata = wdata; t.be = be; t.id = id;
        t.aw_dly = aw_dly; t.w_dly = w_dly; t.b_dly = b_dly; t.b_resp = bresp;
        t.ar_dly = ar_dly; t.r_dly = r_dly; t.nbeats = nbeats; t.rdata = rdata;
        t.r_resp = rresp; t.hold = hold;
        t.exp_addr = 0; t.exp_wdata = 0; t.exp_strb = 0; t.exp_rdata = 0; t.exp_opc = 0; t.exp_lat = 0;
        return t;
    endfunction

    function automatic txn_t rand_txn();
        txn_t t;
        t = mk(1'($urandom_range(0, 1)), $urandom & 32'hFFFF_FFFC, $urandom,
               4'($urandom_range(0, 15)), 5'($urandom_range(0, 31)),
               $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
               2'($urandom_range(0, 3)), $urandom_range(0, 3), $urandom_range(0, 3),
               $urandom_range(1, 3), {$urandom, $urandom}, 2'($urandom_range(0, 3)),
               ($urandom_range(0, 3) == 0));
        return expect_of(t);
    endfunction

    // One transaction: grant (unless already granted in the previous
    // transaction's response cycle), AXI slave with delays, response checks.
    task automatic run_txn(input txn_t t, input txn_t nx, input bit pre);
        int          k, kp, viol, n_aw, n_w, n_b, n_ar, beats, aw_k, w_k, ar_k;
        logic        aw_pend, w_pend, ar_pend, gnt_kp, c_wlast;
        logic [31:0] c_awaddr, c_araddr;
        logic [63:0] c_wdata;
        logic [7:0]  c_strb;
        logic [21:0] c_awfix, c_arfix;
        viol = 0; n_aw = 0; n_w = 0; n_b = 0; n_ar = 0; beats = 0; aw_k = 0; w_k = 0; ar_k = 0;
        aw_pend = 0; w_pend = 0; ar_pend = 0; gnt_kp = 0; c_wlast = 0;
        c_awaddr = 0; c_araddr = 0; c_wdata = 0; c_strb = 0; c_awfix = 0; c_arfix = 0;
        if (!pre) begin
            @(negedge clk);
            idle_axi();
            drive_req(1'b1, t);
            #1;
            chk("grant", gnt, 1'b1);
            chk("busy_idle", busy, 1'b0);
        end
        k = 0; kp = 0;
        while (kp == 0 && k < 100) begin
            @(negedge clk);
            k++;
            drive_req(t.hold, nx);
            aw_ready = (k >= 1 + t.aw_dly);
            w_ready  = (k >= 1 + t.w_dly);
            b_valid  = (n_aw > 0 && n_w > 0 && n_b == 0 &&
                        k >= ((aw_k > w_k) ? aw_k : w_k) + 1 + t.b_dly);
            b_resp   = t.b_resp;
            b_id     = 6'($urandom);
            ar_ready = (k >= 1 + t.ar_dly);
            r_valid  = (n_ar > 0 && beats < t.nbeats && k >= ar_k + 1 + t.r_dly);
            r_last   = r_valid && (beats == t.nbeats - 1);
            r_data   = r_last ? t.rdata : {$urandom, $urandom};
            r_resp   = r_last ? t.r_resp : 2'b10;
            r_id_in  = 6'($urandom);
            #1;
            if (r_valid_o) begin kp = k; gnt_kp = gnt; end
            if (busy !== (kp == 0)) viol++;
            if (kp == 0 && gnt !== 1'b0) viol++;
            if (t.we_n) begin
                if (aw_valid || w_valid || b_ready) viol++;
            end else if (ar_valid || r_ready) viol++;
            if (aw_pend && !aw_valid) viol++;
            if (w_pend && !w_valid) viol++;
            if (ar_pend && !ar_valid) viol++;
            if (b_ready && !(n_aw > 0 && n_w > 0)) viol++;
            if (r_ready && n_ar == 0) viol++;
            if (aw_valid && aw_ready) begin
                n_aw++; aw_k = k; c_awaddr = aw_addr;
                c_awfix = {aw_prot, aw_len, aw_size, aw_burst, aw_id};
            end
            if (w_valid && w_ready) begin
                n_w++; w_k = k; c_wdata = w_data; c_strb = w_strb; c_wlast = w_last;
            end
            if (ar_valid && ar_ready) begin
                n_ar++; ar_k = k; c_araddr = ar_addr;
                c_arfix = {ar_prot, ar_len, ar_size, ar_burst, ar_id};
            end
            if (b_valid && b_ready) n_b++;
            if (r_valid && r_ready) beats++;
            aw_pend = aw_valid && !aw_ready;
            w_pend  = w_valid && !w_ready;
            ar_pend = ar_valid && !ar_ready;
        end
        chk("latency", kp, t.exp_lat);
        chk("protocol", viol, 0);
        chk("gnt_at_resp", gnt_kp, t.hold);
        chk("r_id", r_id, t.id);
        chk("r_rdata", r_rdata, t.exp_rdata);
        chk("r_opc", r_opc, t.exp_opc);
        if (!t.we_n) begin
            chk("aw_count", n_aw, 1);
            chk("w_count", n_w, 1);
            chk("b_count", n_b, 1);
            chk("aw_addr", c_awaddr, t.exp_addr);
            chk("aw_fixed", c_awfix, FIX_EXP);
            chk("w_data", c_wdata, t.exp_wdata);
            chk("w_strb", c_strb, t.exp_strb);
            chk("w_last", c_wlast, 1'b1);
        end else begin
            chk("ar_count", n_ar, 1);
            chk("r_beats", beats, t.nbeats);
            chk("ar_addr", c_araddr, t.exp_addr);
            chk("ar_fixed", c_arfix, FIX_EXP);
        end
        if (!t.hold) begin
            @(negedge clk);
            drive_req(1'b0, t);
            idle_axi();
            #1;
            chk("r_valid_pulse", r_valid_o, 1'b0);
            chk("r_rdata_hold", r_rdata, t.exp_rdata);
            chk("r_id_hold", r_id, t.id);
            chk("r_opc_hold", r_opc, t.exp_opc);
        end
    endtask

    txn_t tbl[8];
    txn_t rq[$];

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int viol;
        // Directed vectors with hand-computed expectations.
        tbl[0] = mk(1'b0, 32'h1000_0004, 32'hDEADBEEF, 4'hF, 5'h03, 0, 0, 0, 2'b00, 0, 0, 1, 64'h0, 2'b00, 1'b0);
        tbl[0].exp_addr = 32'h1000_0004; tbl[0].exp_wdata = 64'hDEADBEEF_DEADBEEF;
        tbl[0].exp_strb = 8'hF0; tbl[0].exp_rdata = 0; tbl[0].exp_opc = 0; tbl[0].exp_lat = 3;
        tbl[1] = mk(1'b1, 32'h1000_0000, 32'h0, 4'h0, 5'h0A, 0, 0, 0, 2'b00, 0, 0, 1, 64'h11223344_55667788, 2'b00, 1'b0);
        tbl[1].exp_addr = 32'h1000_0000; tbl[1].exp_rdata = 32'h55667788; tbl[1].exp_opc = 0; tbl[1].exp_lat = 3;
        tbl[2] = mk(1'b0, 32'h1000_0010, 32'h01020304, 4'h5, 5'h1F, 2, 0, 0, 2'b00, 0, 0, 1, 64'h0, 2'b00, 1'b0);
        tbl[2].exp_addr = 32'h1000_0010; tbl[2].exp_wdata = 64'h01020304_01020304;
        tbl[2].exp_strb = 8'h05; tbl[2].exp_rdata = 0; tbl[2].exp_opc = 0; tbl[2].exp_lat = 5;
        tbl[3] = mk(1'b0, 32'h2000_0008, 32'hCAFEF00D, 4'h3, 5'h02, 0, 0, 0, 2'b10, 0, 0, 1, 64'h0, 2'b00, 1'b0);
        tbl[3].exp_addr = 32'h2000_0008; tbl[3].exp_wdata = 64'hCAFEF00D_CAFEF00D;
        tbl[3].exp_strb = 8'h03; tbl[3].exp_rdata = 0; tbl[3].exp_opc = ERR_EN; tbl[3].exp_lat = 3;
        tbl[4] = mk(1'b0, 32'h0000_00FC, 32'h89ABCDEF, 4'hC, 5'h07, 0, 1, 2, 2'b00, 0, 0, 1, 64'h0, 2'b00, 1'b0);
        tbl[4].exp_addr = 32'h0000_00FC; tbl[4].exp_wdata = 64'h89ABCDEF_89ABCDEF;
        tbl[4].exp_strb = 8'hC0; tbl[4].exp_rdata = 0; tbl[4].exp_opc = 0; tbl[4].exp_lat = 6;
        tbl[5] = mk(1'b1, 32'h3000_000C, 32'h0, 4'h0, 5'h0B, 0, 0, 0, 2'b00, 1, 2, 3, 64'hAABBCCDD_01234567, 2'b01, 1'b0);
        tbl[5].exp_addr = 32'h3000_000C; tbl[5].exp_rdata = 32'hAABBCCDD; tbl[5].exp_opc = 0; tbl[5].exp_lat = 8;
        tbl[6] = mk(1'b0, 32'h4000_0000, 32'h13579BDF, 4'h9, 5'h04, 0, 0, 0, 2'b00, 0, 0, 1, 64'h0, 2'b00, 1'b1);
        tbl[6].exp_addr = 32'h4000_0000; tbl[6].exp_wdata = 64'h13579BDF_13579BDF;
        tbl[6].exp_strb = 8'h09; tbl[6].exp_rdata = 0; tbl[6].exp_opc = 0; tbl[6].exp_lat = 3;
        tbl[7] = mk(1'b1, 32'h4000_0004, 32'h0, 4'h0, 5'h05, 0, 0, 0, 2'b00, 0, 0, 1, 64'hFEDCBA98_76543210, 2'b00, 1'b0);
        tbl[7].exp_addr = 32'h4000_0004; tbl[7].exp_rdata = 32'hFEDCBA98; tbl[7].exp_opc = 0; tbl[7].exp_lat = 3;

        // Reset state.
        rst_ni = 1'b0;
        per_req = 0; per_add = 0; per_we_n = 0; per_wdata = 0; per_be = 0; per_id = 0;
        idle_axi();
        repeat (2) @(negedge clk);
        #1;
        chk("reset_ctrl", {aw_valid, w_valid, ar_valid, b_ready, r_ready, r_valid_o, busy, gnt}, 8'h00);
        chk("reset_resp", {r_opc, r_id, r_rdata}, 38'h0);
        @(negedge clk);
        rst_ni = 1'b1;

        for (int i = 0; i < 8; i++)
            run_txn(tbl[i], (i < 7) ? tbl[i + 1] : tbl[i], (i > 0) && tbl[i - 1].hold);

        // Asynchronous reset while stalled in the read-address phase.
        run_txn(tbl[5], tbl[5], 1'b0);
        @(negedge clk);
        idle_axi();
        drive_req(1'b1, tbl[1]);
        per_id = 5'h11;
        #1;
        chk("rst_seq_gnt", gnt, 1'b1);
        @(negedge clk);
        per_req = 1'b0;
        #1;
        chk("rst_seq_ar_valid_pre", ar_valid, 1'b1);
        chk("rst_seq_busy_pre", busy, 1'b1);
        #1 rst_ni = 1'b0;
        #1;
        chk("rst_ar_valid", ar_valid, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_resp", {r_valid_o, r_opc, r_id, r_rdata}, 39'h0);
        per_req = 1'b1;
        #1;
        chk("rst_gnt_unblocked", gnt, 1'b1);
        per_req = 1'b0;
        @(negedge clk);
        rst_ni = 1'b1;
        viol = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            ar_ready = 1; r_valid = 1; r_last = 1; r_data = {$urandom, $urandom};
            b_valid = 1; aw_ready = 1; w_ready = 1;
            #1;
            if (r_valid_o || ar_valid || busy || aw_valid || w_valid) viol++;
        end
        chk("post_rst_quiet", viol, 0);
        run_txn(tbl[1], tbl[1], 1'b0);

        // Randomized transactions against the reference model.
        for (int i = 0; i < 60; i++) rq.push_back(rand_txn());
        rq[59].hold = 1'b0;
        for (int i = 0; i < 60; i++)
            run_txn(rq[i], (i < 59) ? rq[i + 1] : rq[i], (i > 0) && rq[i - 1].hold);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
